// File: rtl/warp_issue_scheduler_pkg.sv
// warp_issue_scheduler_pkg
// Shared sizing constants and types for the per-SM warp issue scheduler.
//   NUM_WARPS_PER_SM : default number of warps arbitrated per SM
//   WARP_ID_WIDTH    : width of a binary warp id
//   warp_mask_t      : one bit per warp
//   warp_id_t        : binary warp id
package warp_issue_scheduler_pkg;

  localparam int NUM_WARPS_PER_SM = 4;
  localparam int WARP_ID_WIDTH    = $clog2(NUM_WARPS_PER_SM);

  typedef logic [NUM_WARPS_PER_SM-1:0] warp_mask_t;
  typedef logic [WARP_ID_WIDTH-1:0]    warp_id_t;

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// warp_issue_scheduler_if
// Valid/ready issue channel between the warp scheduler and the decode stage.
//   issue_valid   : a selected warp is presented
//   issue_ready   : decode accepts the presented warp
//   issue_warp_id : binary id of the presented warp
//   issue_warp_oh : one-hot of the presented warp, zero when idle
// Modports: master = scheduler side, slave = decode side.
interface warp_issue_scheduler_if
  import warp_issue_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_PER_SM
);

  localparam int ID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                 issue_valid;
  logic                 issue_ready;
  logic [ID_W-1:0]      issue_warp_id;
  logic [NUM_WARPS-1:0] issue_warp_oh;

  modport master (
    output issue_valid,
    output issue_warp_id,
    output issue_warp_oh,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_warp_id,
    input  issue_warp_oh,
    output issue_ready
  );

endinterface

// File: rtl/warp_issue_scheduler_rr_select.sv
// warp_rr_select
// Purely combinational rotating round-robin picker.
//   eligible  : request mask, one bit per warp
//   last_oh   : one-hot of the most recently fired warp; search starts just after it
//   grant_oh  : one-hot of the chosen warp, zero when nothing is eligible
//   grant_id  : binary id of the chosen warp, zero when nothing is eligible
//   any_grant : at least one warp is eligible
module warp_rr_select
  import warp_issue_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_PER_SM
) (
  input  logic [NUM_WARPS-1:0] eligible,
  input  logic [NUM_WARPS-1:0] last_oh,
  output logic [NUM_WARPS-1:0] grant_oh,
  output logic [((NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1)-1:0] grant_id,
  output logic                 any_grant
);

  localparam int ID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic [2*NUM_WARPS-1:0] doubled;
  logic [NUM_WARPS-1:0]   rotated;
  int                     last_idx;
  int                     offset;
  int                     sel;

  // Duplicating the request vector lets the wrap-around search become a
  // plain window starting at last_idx+1; the first set bit in that window
  // is the winner, and its offset is mapped back to an absolute warp id.
  always_comb begin
    last_idx  = 0;
    offset    = 0;
    sel       = 0;
    any_grant = 1'b0;
    grant_oh  = '0;
    grant_id  = '0;
    doubled   = {eligible, eligible};
    rotated   = '0;

    for (int i = 0; i < NUM_WARPS; i++) begin
      if (last_oh[i]) last_idx = i;
    end

    for (int i = 0; i < NUM_WARPS; i++) begin
      rotated[i] = doubled[last_idx + 1 + i];
    end

    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!any_grant && rotated[i]) begin
        any_grant = 1'b1;
        offset    = i;
      end
    end

    sel = last_idx + 1 + offset;
    if (sel >= NUM_WARPS) sel = sel - NUM_WARPS;

    if (any_grant) begin
      grant_oh[sel] = 1'b1;
      grant_id      = ID_W'(sel);
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler
// Per-SM warp scheduler: picks one eligible warp per cycle with rotating
// round-robin priority and presents it to decode over a valid/ready channel.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   warp_active        : per-warp launch mask
//   ibuf_valid         : per-warp instruction-buffer head present
//   ibuf_long          : per-warp head is long-latency (memory/SFU)
//   ibuf_barrier       : per-warp head is a barrier
//   issue (master)     : issue_valid/issue_ready/issue_warp_id/issue_warp_oh
//   ibuf_pop           : one-hot pop to the instruction buffers on fire
//   wb_valid/wb_warp_id: long-latency completion for a warp
//   sched_idle         : no active warp, no pending op, nothing presented
// Build option: define WARP_ISSUE_SCHEDULER_BARRIER_EN to park warps at
// barriers until every active warp has arrived; otherwise barriers issue as
// ordinary instructions.
module warp_issue_scheduler
  import warp_issue_scheduler_pkg::*;
#(
  parameter int NUM_WARPS   = NUM_WARPS_PER_SM,
  parameter int MAX_PENDING = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] warp_active,
  input  logic [NUM_WARPS-1:0] ibuf_valid,
  input  logic [NUM_WARPS-1:0] ibuf_long,
  input  logic [NUM_WARPS-1:0] ibuf_barrier,
  warp_issue_scheduler_if.master issue,
  output logic [NUM_WARPS-1:0] ibuf_pop,
  input  logic                 wb_valid,
  input  logic [((NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1)-1:0] wb_warp_id,
  output logic                 sched_idle
);

  localparam int ID_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [NUM_WARPS-1:0] LAST_OH_RESET = NUM_WARPS'(1) << (NUM_WARPS - 1);

  logic                 fire;
  logic [NUM_WARPS-1:0] fire_oh;
  logic [NUM_WARPS-1:0] held_oh;
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] grant_oh;
  logic [ID_W-1:0]      grant_id;
  logic                 any_grant;
  logic [NUM_WARPS-1:0] last_oh;
  logic [NUM_WARPS-1:0] at_bar;
  logic [NUM_WARPS-1:0] pend_ok;
  logic [NUM_WARPS-1:0] pend_inc;
  logic [NUM_WARPS-1:0] pend_dec;
  logic [NUM_WARPS-1:0] pend_underflow;
  logic                 any_pending;
  logic [PEND_W-1:0]    pending [NUM_WARPS];

  assign fire     = issue.issue_valid & issue.issue_ready;
  assign fire_oh  = issue.issue_warp_oh & {NUM_WARPS{fire}};
  assign held_oh  = issue.issue_warp_oh & {NUM_WARPS{issue.issue_valid & ~issue.issue_ready}};
  assign ibuf_pop = fire_oh;

  // Per-warp bookkeeping terms: credit check, increment on a long-latency
  // fire, decrement on writeback, and a zero-pending writeback detector.
  always_comb begin
    pend_ok        = '0;
    pend_inc       = '0;
    pend_dec       = '0;
    pend_underflow = '0;
    any_pending    = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pend_ok[w]        = (pending[w] < PEND_W'(MAX_PENDING));
      pend_inc[w]       = fire_oh[w] & ibuf_long[w];
      pend_dec[w]       = wb_valid & (wb_warp_id == ID_W'(w));
      pend_underflow[w] = pend_dec[w] & ~pend_inc[w] & (pending[w] == '0);
      if (pending[w] != '0) any_pending = 1'b1;
    end
  end

  // A warp sitting in the output register (held or firing) is kept out of
  // the search so the next slot can go to somebody else.
  assign eligible = warp_active & ibuf_valid & pend_ok & ~at_bar & ~held_oh & ~fire_oh;

  assign sched_idle = ~(|warp_active) & ~any_pending & ~issue.issue_valid;

  warp_rr_select #(
    .NUM_WARPS (NUM_WARPS)
  ) u_select (
    .eligible  (eligible),
    .last_oh   (last_oh),
    .grant_oh  (grant_oh),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  // Output register: reloads whenever it is empty or being accepted, and is
  // frozen while decode back-pressures. The id keeps its last value when
  // nothing is presented. Priority pointer moves only on an actual fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue.issue_valid   <= 1'b0;
      issue.issue_warp_id <= '0;
      issue.issue_warp_oh <= '0;
      last_oh             <= LAST_OH_RESET;
    end else begin
      if (fire) last_oh <= issue.issue_warp_oh;
      if (!issue.issue_valid || issue.issue_ready) begin
        if (any_grant) begin
          issue.issue_valid   <= 1'b1;
          issue.issue_warp_oh <= grant_oh;
          issue.issue_warp_id <= grant_id;
        end else begin
          issue.issue_valid   <= 1'b0;
          issue.issue_warp_oh <= '0;
        end
      end
    end
  end

  // Outstanding long-latency counters. A simultaneous increment and
  // decrement cancel; deactivating a warp wipes its count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) pending[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (!warp_active[w]) begin
          pending[w] <= '0;
        end else if (pend_inc[w] && !pend_dec[w] && (pending[w] != PEND_W'(MAX_PENDING))) begin
          pending[w] <= pending[w] + PEND_W'(1);
        end else if (pend_dec[w] && !pend_inc[w] && (pending[w] != '0)) begin
          pending[w] <= pending[w] - PEND_W'(1);
        end
      end
    end
  end

  wb_without_pending: assert property (@(posedge clk) disable iff (!reset) pend_underflow == '0);

`ifdef WARP_ISSUE_SCHEDULER_BARRIER_EN
  logic bar_release;

  // Release once every still-active warp has parked; inactive warps count
  // as arrived so a warp leaving early cannot deadlock the rest.
  assign bar_release = (&(at_bar | ~warp_active)) & (|at_bar);

  // Barrier flags: set on a barrier fire, cleared together on release or
  // individually when the warp is deactivated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      at_bar <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (!warp_active[w]) begin
          at_bar[w] <= 1'b0;
        end else if (bar_release) begin
          at_bar[w] <= 1'b0;
        end else if (fire_oh[w] && ibuf_barrier[w]) begin
          at_bar[w] <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_barrier;

  assign at_bar         = '0;
  assign unused_barrier = ^ibuf_barrier;
`endif

endmodule
